// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch stage
package fetch_pkg;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   typedef enum logic [1:0] {PC_SEQ, PC_HOLD, PC_BRANCH, PC_TRAP} next_pc_sel_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: priority select of the next PC (trap > branch > stall > sequential); FETCH_MISALIGN_CHECK_EN adds target_misaligned
module next_pc_sel
   import fetch_pkg::*;
(
   input  logic [31:0]  pc,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic [31:0]  branch_target,
   input  logic         trap_req,
   input  logic [31:0]  trap_vector,
   output next_pc_sel_t sel,
   output logic [31:0]  next_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,output logic        target_misaligned
`endif
);
   logic [31:0] target;
   // select source, then force redirect targets onto a word boundary
   always_comb begin
      sel     = trap_req ? PC_TRAP : branch_taken ? PC_BRANCH : stall ? PC_HOLD : PC_SEQ;
      target  = trap_req ? trap_vector : branch_target;
      next_pc = sel == PC_SEQ ? pc + 32'd4 : sel == PC_HOLD ? pc : target & ~32'd3;
   end
`ifdef FETCH_MISALIGN_CHECK_EN
   assign target_misaligned = (trap_req | branch_taken) & (|target[1:0]);
`endif
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage holding the PC and IF/ID register; FETCH_MISALIGN_CHECK_EN enables fetch_misaligned
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          IMEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        trap_req,
   input  logic [31:0] trap_vector,
   input  logic [31:0] Instruction,
   output logic [31:0] PC_Value,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        fetch_oor
`ifdef FETCH_MISALIGN_CHECK_EN
   ,output logic       fetch_misaligned
`endif
);
   logic [31:0]  pc;
   logic [31:0]  next_pc;
   next_pc_sel_t sel;
   if_id_t       if_id;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic         target_misaligned;
`endif

   next_pc_sel u_sel (
      .pc                (pc),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .trap_req          (trap_req),
      .trap_vector       (trap_vector),
      .sel               (sel),
      .next_pc           (next_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,.target_misaligned(target_misaligned)
`endif
   );

   assign PC_Value       = pc;
   assign fetch_oor      = pc >= 32'(IMEM_DEPTH * 4);
   assign if_id_pc       = if_id.pc;
   assign if_id_pc_plus4 = if_id.pc_plus4;
   assign if_id_instr    = if_id.instr;
   assign if_id_valid    = if_id.valid;

   // PC advance and IF/ID capture; redirects and out-of-range fetches load a bubble, stall holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= RESET_PC;
         if_id <= if_id_t'{pc: 32'd0, pc_plus4: 32'd4, instr: NOP_INSTR, valid: 1'b0};
      end else begin
         pc <= next_pc;
         if (sel != PC_HOLD)
            if_id <= (sel == PC_SEQ && !fetch_oor)
                     ? if_id_t'{pc: pc, pc_plus4: pc + 32'd4, instr: Instruction, valid: 1'b1}
                     : if_id_t'{pc: pc, pc_plus4: pc + 32'd4, instr: NOP_INSTR, valid: 1'b0};
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // one-cycle flag after a redirect whose target had nonzero low bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) fetch_misaligned <= 1'b0;
      else       fetch_misaligned <= target_misaligned;
   end
`endif
endmodule
